// File: rtl/mdio_pkg.sv
// Shared types and constants for the Clause-22 MDIO status poller.
package mdio_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_CMD  = 3'd2,
        ST_TA   = 3'd3,
        ST_DATA = 3'd4,
        ST_DONE = 3'd5
    } mdio_state_t;

    localparam logic [1:0] MDIO_ST    = 2'b01;
    localparam logic [1:0] MDIO_OP_RD = 2'b10;

    // Frame bit boundaries: first bit index of the following field.
    localparam int PRE_BITS   = 32;
    localparam int CMD_END    = 46;
    localparam int TA_END     = 48;
    localparam int FRAME_BITS = 64;

    localparam logic [1:0] SPD_1000 = 2'b10;
    localparam logic [1:0] SPD_100  = 2'b01;
    localparam logic [1:0] SPD_10   = 2'b00;

endpackage

// File: rtl/mdio_clk_gen.sv
// MDC divider: CLK_DIV clk cycles per half period, low phase first.
// Held low with its counter cleared while disabled so every frame starts
// from a fresh low phase.
module mdio_clk_gen #(
    parameter int CLK_DIV = 25
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    output logic mdc_o,
    output logic fall_tick_o,
    output logic rise_tick_o
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          mdc_q, mdc_d;
    logic          term;

    assign term        = (cnt_q == CW'(CLK_DIV - 1));
    assign rise_tick_o = en_i & term & ~mdc_q;
    assign fall_tick_o = en_i & term &  mdc_q;
    assign mdc_o       = mdc_q;

    // Next-state for the half-period counter and MDC level.
    always_comb begin
        cnt_d = cnt_q;
        mdc_d = mdc_q;
        if (!en_i) begin
            cnt_d = '0;
            mdc_d = 1'b0;
        end else if (term) begin
            cnt_d = '0;
            mdc_d = ~mdc_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Divider registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            mdc_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            mdc_q <= mdc_d;
        end
    end

endmodule

// File: rtl/mdio_link_poller.sv
// Clause-22 MDIO master that periodically reads the PHY status register and
// publishes speed/link qualifiers, held constant between polls.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting out the poll interval, MDC low, bus released
// PRE     | 32-bit preamble of ones
// CMD     | ST, OP, PHY address, register address (frame bits 32-45)
// TA      | turnaround, bus released (frame bits 46-47)
// DATA    | 16 bits shifted in from the PHY (frame bits 48-63)
// DONE    | one cycle: results published, rd_valid high
module mdio_link_poller
    import mdio_pkg::*;
#(
    parameter int         CLK_DIV     = 25,
    parameter int         POLL_CYCLES = 1250000,
    parameter logic [4:0] PHY_ADDR    = 5'b00001,
    parameter logic [4:0] STAT_REG    = 5'h11,
    parameter int         SPD_MSB     = 15,
    parameter int         LINK_BIT    = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mdc,
    output logic        mdio_o,
    output logic        mdio_oe,
    input  logic        mdio_i,
    output logic [1:0]  speed,
    output logic        link,
    output logic [15:0] rd_data,
    output logic        rd_valid
);

    localparam int PW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;

    // Padded to 16 bits so a 4-bit index can never fall off the end.
    localparam logic [15:0] CMD_WORD = {2'b11, MDIO_ST, MDIO_OP_RD, PHY_ADDR, STAT_REG};

    mdio_state_t   state_q, state_d;
    logic [5:0]    bit_q, bit_d, bit_nx;
    logic [PW-1:0] poll_q, poll_d;
    logic [15:0]   shift_q, shift_d;
    logic [1:0]    sync_q;
    logic          mdio_o_q, mdio_o_d;
    logic          mdio_oe_q, mdio_oe_d;
    logic [15:0]   rd_data_q, rd_data_d;
    logic          rd_valid_q, rd_valid_d;
    logic [1:0]    speed_q, speed_d;
    logic          link_q, link_d;
    logic          fall_tick, rise_tick, clk_en;
    logic [3:0]    cmd_idx;
    logic [1:0]    spd_fld;

    assign clk_en  = (state_q != ST_IDLE);
    assign bit_nx  = bit_q + 6'd1;
    assign cmd_idx = 4'(6'(CMD_END - 1) - bit_nx);
    assign spd_fld = shift_q[SPD_MSB -: 2];

    mdio_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk         (clk),
        .rst_n       (rst_n),
        .en_i        (clk_en),
        .mdc_o       (mdc),
        .fall_tick_o (fall_tick),
        .rise_tick_o (rise_tick)
    );

    // Two-stage synchronizer for the asynchronous MDIO input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], mdio_i};
        end
    end

    // Frame sequencing, bus drive, capture and decode.
    always_comb begin
        state_d    = state_q;
        bit_d      = bit_q;
        poll_d     = poll_q;
        shift_d    = shift_q;
        mdio_o_d   = mdio_o_q;
        mdio_oe_d  = mdio_oe_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        speed_d    = speed_q;
        link_d     = link_q;

        case (state_q)
            ST_IDLE: begin
                if (poll_q == PW'(POLL_CYCLES - 1)) begin
                    // MDC is already low, so bit 0 is driven on the way out.
                    state_d   = ST_PRE;
                    bit_d     = 6'd0;
                    mdio_o_d  = 1'b1;
                    mdio_oe_d = 1'b1;
                end else begin
                    poll_d = poll_q + PW'(1);
                end
            end

            ST_PRE, ST_CMD, ST_TA, ST_DATA: begin
                if (state_q == ST_DATA && rise_tick) begin
                    shift_d = {shift_q[14:0], sync_q[1]};
                end
                if (fall_tick) begin
                    if (bit_q == 6'(FRAME_BITS - 1)) begin
                        state_d    = ST_DONE;
                        mdio_o_d   = 1'b1;
                        mdio_oe_d  = 1'b0;
                        rd_data_d  = shift_q;
                        rd_valid_d = 1'b1;
                        if (shift_q == 16'hFFFF) begin
                            link_d = 1'b0;
                        end else if (!shift_q[LINK_BIT]) begin
                            link_d = 1'b0;
                        end else begin
                            link_d = 1'b1;
                            case (spd_fld)
                                SPD_1000, SPD_100, SPD_10: speed_d = spd_fld;
                                default:                   speed_d = speed_q;
                            endcase
                        end
                    end else begin
                        bit_d = bit_nx;
                        if (bit_nx < 6'(PRE_BITS)) begin
                            state_d   = ST_PRE;
                            mdio_o_d  = 1'b1;
                            mdio_oe_d = 1'b1;
                        end else if (bit_nx < 6'(CMD_END)) begin
                            state_d   = ST_CMD;
                            mdio_o_d  = CMD_WORD[cmd_idx];
                            mdio_oe_d = 1'b1;
                        end else if (bit_nx < 6'(TA_END)) begin
                            state_d   = ST_TA;
                            mdio_o_d  = 1'b1;
                            mdio_oe_d = 1'b0;
                        end else begin
                            state_d   = ST_DATA;
                            mdio_o_d  = 1'b1;
                            mdio_oe_d = 1'b0;
                        end
                    end
                end
            end

            ST_DONE: begin
                // The DONE cycle is the first cycle of the poll interval.
                state_d = ST_IDLE;
                poll_d  = PW'(1);
            end

            default: begin
                state_d   = ST_IDLE;
                mdio_o_d  = 1'b1;
                mdio_oe_d = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            bit_q      <= 6'd0;
            poll_q     <= PW'(POLL_CYCLES - 1);
            shift_q    <= 16'h0000;
            mdio_o_q   <= 1'b1;
            mdio_oe_q  <= 1'b0;
            rd_data_q  <= 16'h0000;
            rd_valid_q <= 1'b0;
            speed_q    <= SPD_10;
            link_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_q      <= bit_d;
            poll_q     <= poll_d;
            shift_q    <= shift_d;
            mdio_o_q   <= mdio_o_d;
            mdio_oe_q  <= mdio_oe_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            speed_q    <= speed_d;
            link_q     <= link_d;
        end
    end

    assign mdio_o   = mdio_o_q;
    assign mdio_oe  = mdio_oe_q;
    assign speed    = speed_q;
    assign link     = link_q;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

endmodule

// File: doc/mdio_link_poller.md
# mdio_link_poller

Clause-22 MDIO management master that periodically reads the PHY status register and produces the `speed[1:0]` and `link` qualifiers consumed by the GMII speed arbiter. It generates MDC from the 125 MHz system clock, runs a read frame every poll interval, decodes the speed and link fields, and holds them stable between polls. It sits between the PHY management pins (via an external tri-state buffer) and the arbiter's `speed`/`link` inputs.

## Interface
Parameters:
- `CLK_DIV`, 25: MDC half-period in clk cycles (125 MHz clk gives 2.5 MHz MDC). Must be ≥ 4.
- `POLL_CYCLES`, 1250000: clk cycles from the end of one frame to the start of the next (10 ms).
- `PHY_ADDR`, 5'b00001: PHY address.
- `STAT_REG`, 5'h11: status register address.
- `SPD_MSB`, 15: speed field MSB. The LSB is at `SPD_MSB-1`.
- `LINK_BIT`, 10: link-status bit index.

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous, active-low reset
- `mdc`  out  1  management clock
- `mdio_o`  out  1  MDIO output data
- `mdio_oe`  out  1  MDIO output enable (1 = drive)
- `mdio_i`  in  1  MDIO input (asynchronous; 2-FF synchronized internally)
- `speed`  out  2  2'b10 = 1000M, 2'b01 = 100M, 2'b00 = 10M
- `link`  out  1  link up
- `rd_data`  out  16  last read register value
- `rd_valid`  out  1  one-cycle pulse when a frame completes

## Operation
- States: IDLE → PRE → CMD → TA → DATA → DONE → IDLE.
- **IDLE:** `poll_cnt` counts up to `POLL_CYCLES-1`, then the block enters PRE. MDC is held low. Reset loads `poll_cnt = POLL_CYCLES-1`, so the first frame starts on the first clk after reset release.
- **Bit cell:** each bit is one MDC period. The low phase comes first (`CLK_DIV` cycles), then the high phase (`CLK_DIV` cycles).
  - `mdio_o` and `mdio_oe` update on the clk where MDC goes low.
  - The synchronized `mdio_i` is sampled on the clk where MDC goes high.
- **Frame:** 64 bits, MSB first, tracked by a 6-bit counter.
  - PRE: 32 × '1'.
  - CMD: 14 bits, ST = 01, OP = 10, then PHY_ADDR, then STAT_REG. Frame bits 32–45.
  - TA: 2 bits, `mdio_oe = 0`. Frame bits 46–47.
  - DATA: 16 bits shifted in from sampled `mdio_i`. Frame bits 48–63.
- `mdio_oe = 1` only during PRE and CMD. At all other times `mdio_oe = 0` and `mdio_o = 1`.
- **DONE:** one clk long.
  - `rd_data` ← shift register, and `rd_valid` = 1.
  - Decode is applied in this order:
    1. Read value 16'hFFFF (no PHY / bus pulled up): `link` ← 0, `speed` held.
    2. Link bit = 0: `link` ← 0, `speed` held.
    3. Link bit = 1: `link` ← 1. `speed` ← field if the field is 00, 01 or 10. Reserved field 11 holds `speed`.
- `speed` and `link` change only in DONE. Between polls they are glitch-free and constant.
- The TA second bit driven by the PHY (expected 0) is not checked.

## Timing
- Reset values: `mdc` 0, `mdio_o` 1, `mdio_oe` 0, `speed` 2'b00, `link` 0, `rd_data` 16'h0000, `rd_valid` 0.
- **Frame length:** the clk on which the block leaves IDLE is cycle 0.
  - MDC rising edges fall on cycles `CLK_DIV + 2·CLK_DIV·k`, for k = 0..63.
  - `rd_valid` is high in cycle `128·CLK_DIV`.
- The next frame starts exactly `POLL_CYCLES` clk cycles after the `rd_valid` cycle.
- Input sampling latency is 2 clk (synchronizer). It must be less than `CLK_DIV`, which `CLK_DIV` ≥ 4 guarantees.
- **Reset mid-frame:** all outputs return to reset values immediately (async). The frame is abandoned and `speed`/`link` are not updated. A new frame starts on the first clk after release.
- Outputs are registered, with no combinational path from `mdio_i`.

## Structure
- Package `mdio_pkg` holds:
  - the state enum;
  - constants `MDIO_ST = 2'b01`, `MDIO_OP_RD = 2'b10`;
  - bit-boundary constants `PRE_BITS = 32`, `CMD_END = 46`, `TA_END = 48`, `FRAME_BITS = 64`;
  - speed encodings `SPD_1000 = 2'b10`, `SPD_100 = 2'b01`, `SPD_10 = 2'b00`.
- Sub-module `mdio_clk_gen`: the `CLK_DIV` divider. Outputs `mdc`, `fall_tick` and `rise_tick`. It is enabled only outside IDLE, and holds `mdc` low and its counter at 0 when disabled.
- The top level holds the FSM, bit counter, poll counter, shift register, synchronizer and decode.

## Test plan
Bench settings: `CLK_DIV = 4`, `POLL_CYCLES = 1000`, plus a behavioural PHY model.

1. **Reset and frame format:** release reset → frame starts 1 clk later with MDC period 8 clk. Captured MOSI bits are 32 × '1', then 0110_00001_10001. `mdio_oe` falls at bit 46. `rd_valid` pulses at cycle 512.
2. **1000M link up:** PHY returns 16'h8400 → `rd_data` = 16'h8400, `speed` = 2'b10, `link` = 1. The next frame starts exactly 1000 clk after the `rd_valid` cycle.
3. **100M then link down:** PHY returns 16'h4400 → `speed` 01, `link` 1. Next poll returns 16'h0000 → `link` 0, `speed` stays 01.
4. **No PHY, then reserved speed:** PHY returns 16'hFFFF → `link` 0, `speed` held. Next poll returns 16'hC400 → `link` 1, `speed` held.
5. **Reset mid-frame:** assert `rst_n` low during frame bit 40 → `mdc` 0, `mdio_oe` 0, `speed`/`link` at reset values in the same cycle. After release, a complete new frame and correct decode follow.
6. **Alternating reads:** PHY alternates 16'h0400 and 16'h8400 each poll → `speed` toggles 00 ↔ 10 only in DONE cycles, with exactly one `rd_valid` pulse per frame.
